// File: rtl/dcache_mem_sched.sv
// Data-cache memory scheduler: arbitrates committed stores against load-miss MSHR issue,
// tracks outstanding misses by memory tag, and registers the returning fill for the cache.
module dcache_mem_sched #(
  parameter int MSHR_ENTRIES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        st_req_valid,
  input  logic [31:0] st_req_addr,
  input  logic [63:0] st_req_data,
  input  logic [1:0]  st_req_size,
  output logic        st_req_done,
  input  logic        ld_req_valid,
  input  logic [31:0] ld_req_addr,
  output logic        ld_req_ready,
  output logic [1:0]  proc2Dmem_command,
  output logic [31:0] proc2Dmem_addr,
  output logic [63:0] proc2Dmem_data,
  output logic [1:0]  proc2Dmem_size,
  input  logic [3:0]  Dmem2proc_response,
  input  logic [63:0] Dmem2proc_data,
  input  logic [3:0]  Dmem2proc_tag,
  output logic [4:0]  Dmem2proc_idx,
  output logic [7:0]  Dmem2proc_tag_out,
  output logic [63:0] Dmem2proc_fill_data,
  output logic        Dmem2proc_valid,
  output logic        mshr_full
);

  localparam int IDX_W = (MSHR_ENTRIES > 1) ? $clog2(MSHR_ENTRIES) : 1;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  typedef enum logic [1:0] {ST_INVALID, ST_WAIT, ST_PEND} mshr_state_e;

  mshr_state_e r_state [MSHR_ENTRIES];
  mshr_state_e w_state_nxt [MSHR_ENTRIES];
  logic [28:0] r_addr [MSHR_ENTRIES];
  logic [28:0] w_addr_nxt [MSHR_ENTRIES];
  logic [3:0]  r_tag [MSHR_ENTRIES];
  logic [3:0]  w_tag_nxt [MSHR_ENTRIES];

  logic [MSHR_ENTRIES-1:0] w_cmp_hit;
  logic             w_any_wait, w_any_free, w_cmp_any, w_merge;
  logic [IDX_W-1:0] w_wait_idx, w_free_idx, w_cmp_idx;
  logic             w_ld_issue, w_accept, w_alloc;
  logic             w_unused_ok;

  logic        r_fill_vld_p1;
  logic [4:0]  r_fill_idx_p1;
  logic [7:0]  r_fill_tag_p1;
  logic [63:0] r_fill_data_p1;

  assign w_unused_ok = ^ld_req_addr[2:0];

  // Entry scan runs high-to-low so the lowest index wins every priority pick.
  always_comb begin
    w_cmp_hit  = '0;
    w_any_wait = 1'b0;
    w_wait_idx = '0;
    w_any_free = 1'b0;
    w_free_idx = '0;
    w_cmp_any  = 1'b0;
    w_cmp_idx  = '0;
    w_merge    = 1'b0;
    for (int i = MSHR_ENTRIES - 1; i >= 0; i--) begin
      w_cmp_hit[i] = (Dmem2proc_tag != 4'd0) && (r_state[i] == ST_PEND) &&
                     (r_tag[i] == Dmem2proc_tag);
      if (r_state[i] == ST_WAIT) begin
        w_any_wait = 1'b1;
        w_wait_idx = IDX_W'(i);
      end
      if (r_state[i] == ST_INVALID) begin
        w_any_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (w_cmp_hit[i]) begin
        w_cmp_any = 1'b1;
        w_cmp_idx = IDX_W'(i);
      end
      if ((r_state[i] != ST_INVALID) && !w_cmp_hit[i] && (r_addr[i] == ld_req_addr[31:3]))
        w_merge = 1'b1;
    end
  end

  assign w_ld_issue   = !st_req_valid && w_any_wait;
  assign w_accept     = (Dmem2proc_response != 4'd0);
  assign st_req_done  = st_req_valid && w_accept;
  assign ld_req_ready = w_merge || w_any_free;
  assign w_alloc      = ld_req_valid && !w_merge && w_any_free;

  always_comb begin
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr    = 32'd0;
    proc2Dmem_data    = 64'd0;
    proc2Dmem_size    = SZ_DOUBLE;
    if (st_req_valid) begin
      proc2Dmem_command = BUS_STORE;
      proc2Dmem_addr    = st_req_addr;
      proc2Dmem_data    = st_req_data;
      proc2Dmem_size    = st_req_size;
    end else if (w_any_wait) begin
      proc2Dmem_command = BUS_LOAD;
      proc2Dmem_addr    = {r_addr[w_wait_idx], 3'b000};
    end
  end

  // Issue, allocation and completion can each touch a different entry in the same cycle.
  always_comb begin
    for (int i = 0; i < MSHR_ENTRIES; i++) begin
      w_state_nxt[i] = r_state[i];
      w_addr_nxt[i]  = r_addr[i];
      w_tag_nxt[i]   = r_tag[i];
      if (w_cmp_hit[i])
        w_state_nxt[i] = ST_INVALID;
      if (w_ld_issue && w_accept && (IDX_W'(i) == w_wait_idx)) begin
        w_state_nxt[i] = ST_PEND;
        w_tag_nxt[i]   = Dmem2proc_response;
      end
      if (w_alloc && (IDX_W'(i) == w_free_idx)) begin
        w_state_nxt[i] = ST_WAIT;
        w_addr_nxt[i]  = ld_req_addr[31:3];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < MSHR_ENTRIES; i++) begin
      if (reset) begin
        r_state[i] <= ST_INVALID;
        r_tag[i]   <= 4'd0;
      end else begin
        r_state[i] <= w_state_nxt[i];
        r_tag[i]   <= w_tag_nxt[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < MSHR_ENTRIES; i++)
      r_addr[i] <= w_addr_nxt[i];
  end

  always_comb begin
    mshr_full = 1'b1;
    for (int i = 0; i < MSHR_ENTRIES; i++)
      if (r_state[i] == ST_INVALID) mshr_full = 1'b0;
  end

  // Stage p0 -> p1: completion match registered into the cache fill port.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fill_vld_p1  <= 1'b0;
      r_fill_idx_p1  <= 5'd0;
      r_fill_tag_p1  <= 8'd0;
      r_fill_data_p1 <= 64'd0;
    end else begin
      r_fill_vld_p1  <= w_cmp_any;
      r_fill_idx_p1  <= w_cmp_any ? r_addr[w_cmp_idx][4:0]  : 5'd0;
      r_fill_tag_p1  <= w_cmp_any ? r_addr[w_cmp_idx][12:5] : 8'd0;
      r_fill_data_p1 <= w_cmp_any ? Dmem2proc_data : 64'd0;
    end
  end

  assign Dmem2proc_valid     = r_fill_vld_p1;
  assign Dmem2proc_idx       = r_fill_idx_p1;
  assign Dmem2proc_tag_out   = r_fill_tag_p1;
  assign Dmem2proc_fill_data = r_fill_data_p1;

endmodule

// File: doc/dcache_mem_sched.md
DCACHE_MEM_SCHED -- requirements
Module: dcache_mem_sched

Interface
REQ-001 SHALL have parameter MSHR_ENTRIES, default 4: number of outstanding load-miss entries (2..8).
REQ-002 SHALL have clock  input  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have reset  input  1: reset is synchronous and active-high.
REQ-004 SHALL have st_req_valid  input  1: a committed store needs memory.
REQ-005 SHALL have st_req_addr, st_req_data, st_req_size  input  32/64/2: store address, store data, store size (BYTE/HALF/WORD/DOUBLE).
REQ-006 SHALL have st_req_done  output  1: store accepted by memory; the ROB may retire it.
REQ-007 SHALL have ld_req_valid, ld_req_addr  input  1/32: load miss from the dcache controller.
REQ-008 SHALL have ld_req_ready  output  1: the load miss is accepted this cycle (allocated or merged).
REQ-009 SHALL have proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, proc2Dmem_size  output  2/32/64/2: memory request.
REQ-010 SHALL have Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag  input  4/64/4: accept tag (0 = rejected), fill data, fill tag (0 = none).
REQ-011 SHALL have Dmem2proc_idx, Dmem2proc_tag_out, Dmem2proc_fill_data, Dmem2proc_valid  output  5/8/64/1: cache fill index, cache tag, data and write enable.
REQ-012 SHALL have mshr_full  output  1: all entries are non-INVALID.

Function
REQ-013 Each entry SHALL hold a state (INVALID, WAIT, PEND), a block address addr[31:3], and a 4-bit mem tag.
REQ-014 Arbitration SHALL be: a store request has priority; otherwise the lowest-index WAIT entry issues; otherwise BUS_NONE, addr 0, data 0, size DOUBLE.
REQ-015 A store SHALL drive BUS_STORE with st_req_addr, st_req_data and st_req_size; st_req_done SHALL be combinational: st_req_valid & store selected & Dmem2proc_response != 0.
REQ-016 A rejected store (response 0) SHALL be re-driven every cycle until accepted; st_req_done SHALL stay 0 meanwhile.
REQ-017 A load issue SHALL drive BUS_LOAD, addr {entry.addr,3'b000}, size DOUBLE, data 0.
REQ-018 If the load issue is accepted (response != 0), the entry SHALL go WAIT->PEND and latch the response as its tag at the clock edge; if rejected, it SHALL stay WAIT.
REQ-019 ld_req_ready SHALL be 1 if ld_req_addr[31:3] matches a WAIT/PEND entry that is not completing this cycle (merge, no allocation), or if an INVALID entry exists.
REQ-020 On allocation, the lowest-index INVALID entry SHALL go to WAIT at the edge; it is not issuable in the allocation cycle (earliest issue: next cycle).
REQ-021 If ld_req_valid=0, no allocation or merge SHALL occur; ld_req_ready SHALL be an ignored don't-care-free value computed as in REQ-019.
REQ-022 On completion, a nonzero Dmem2proc_tag matching a PEND entry's tag SHALL register a fill: the next cycle has Dmem2proc_valid=1, idx=addr[7:3], tag_out=addr[15:8], fill_data=Dmem2proc_data; otherwise Dmem2proc_valid=0 and the fill fields are 0.
REQ-023 The completing entry SHALL go to INVALID at that edge; it SHALL NOT be reallocated in the same cycle.
REQ-024 A nonzero Dmem2proc_tag matching no PEND entry (e.g. a store tag) SHALL be ignored.
REQ-025 Issue, allocation and completion SHALL all be allowed in one cycle on different entries.
REQ-026 A request matching a completing entry SHALL allocate a new entry; if none is free, ld_req_ready=0.
REQ-027 mshr_full SHALL be computed from registered state only.

Reset
REQ-028 While reset=1 at an edge, all entries SHALL become INVALID with tag 0 and the fill register SHALL clear.
REQ-029 After reset: Dmem2proc_valid=0, mshr_full=0, and the memory outputs SHALL be BUS_NONE/0/0/DOUBLE unless st_req_valid=1.
REQ-030 Reset mid-operation SHALL discard all outstanding entries; later responses carrying their tags SHALL be ignored.

Verification
REQ-031 Load miss 0x1238, response 3, then tag 3 with data 0xAABB -> next cycle valid=1, idx=7, tag_out=0x12, data=0xAABB; entry becomes INVALID.
REQ-032 st_req_valid and a WAIT load in the same cycle, response 5 -> BUS_STORE issued with st_req_done=1; load issues the next cycle.
REQ-033 Store rejected for 3 cycles, then response 2 -> command held as BUS_STORE for 4 cycles; st_req_done=1 only in cycle 4.
REQ-034 Four misses to distinct blocks -> mshr_full=1; fifth distinct miss gets ld_req_ready=0; a miss to 0x1238 while pending gets ld_req_ready=1 with no new entry.
REQ-035 Completion of entry 0 with a new miss in the same cycle while full -> ld_req_ready=0; the next cycle ready=1 and entry 0 is allocated.
REQ-036 Reset with 2 PEND entries, then their tags return -> Dmem2proc_valid stays 0.
